shifter_pipe: RTL and testbench
===============================

Name: shifter_pipe

Overview:
Parametrised, pipelined barrel shifter. Successor to the single-cycle 32-bit combinational shifter/reverser pair. Supports four modes (SLL, SRL, SRA, ROR) at any power-of-two width, with one register stage per shift level and a valid/ready handshake on both sides. Sits between the ALU operand mux and the writeback stage; also usable standalone as a multi-issue shift unit.

Parameters:
WIDTH, 32, data width in bits; power of two, 8..64.
SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.
TAGW, 4, width of the opaque tag carried alongside each operation.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  input operation present.
in_ready  out  1  pipeline accepts the input this cycle.
in_data  in  WIDTH  operand to shift.
in_amt  in  SHW  shift amount; only the low SHW bits exist.
in_op  in  2  mode: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
in_tag  in  TAGW  opaque tag, returned unchanged with the result.
out_valid  out  1  result present.
out_ready  in  1  consumer accepts the result this cycle.
out_data  out  WIDTH  shifted result.
out_tag  out  TAGW  tag of the result.

Behaviour:
- Core is a right shifter. For SLL, data is bit-reversed on entry and the result is bit-reversed on exit. The reversed flag travels down the pipe with the operation.
- Pipeline has SHW levels. Level k shifts right by 2^k when amt[k]=1. Levels run LSB first.
- A register follows every level. Latency from accept to out_valid is exactly SHW cycles (5 at WIDTH=32).
- Fill bits per level:
  - SLL/SRL: 0.
  - SRA: sign bit of the original in_data, captured at entry and carried per stage.
  - ROR: bits shifted out at the bottom wrap to the top.
- Each stage register holds: valid, data, remaining amt bits, op, rev flag, sign, tag.
- Global stall: advance = !out_valid || out_ready. in_ready = advance, which is combinational from out_valid/out_ready.
- Input is accepted when in_valid && in_ready. When advance=1 and no input is accepted, a bubble (valid=0) enters stage 0.
- When advance=0, all stages hold. Bubbles are not compressed.
- Throughput: one operation per cycle while out_ready=1.
- Output is stable while out_valid=1 && out_ready=0: out_data and out_tag must not change.
- Amount 0 returns in_data unchanged in all modes.
- Amount WIDTH-1 in SRA yields all copies of the sign bit.
- Reset:
  - All stage valid bits clear; out_valid=0, out_data=0, out_tag=0.
  - in_ready=1 in the first cycle after reset.
  - Reset asserted mid-operation discards every in-flight operation. No result is emitted for them.
- If rst and in_valid are both asserted in the same cycle, the input is not accepted.
- No internal state other than the stage registers.

Test Plan:
1. WIDTH=32, SRL, in_data=32'hFFFF_FFFF, amt swept 0..31 back-to-back, out_ready=1 -> 32 results, each 32'hFFFF_FFFF>>amt. First result 5 cycles after the first accept; one result per cycle thereafter; tags in order.
2. SLL, in_data=32'h0000_0001, amt=31 -> 32'h8000_0000. SRA, in_data=32'h8000_0000, amt=4 -> 32'hF800_0000. SRA, in_data=32'h7000_0000, amt=4 -> 32'h0700_0000.
3. ROR, in_data=32'h1234_5678, amt=8 -> 32'h7812_3456. Same data with amt=0 -> 32'h1234_5678.
4. Backpressure: issue 8 ops; hold out_ready=0 for 10 cycles after the first out_valid -> in_ready=0 while stalled; out_data/out_tag constant; after release, all 8 results delivered in order with no loss or duplication.
5. Reset mid-stream: 3 ops in flight; assert rst for 1 cycle -> out_valid=0 and out_data=0 the next cycle; none of the 3 results ever appear; a new op issued after reset returns correctly after 5 cycles.
6. WIDTH=8 instance, SRA, in_data=8'h90, amt=3 -> 8'hF2. Latency 3 cycles.

Source files
------------

// File: rtl/shifter_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | shifter_pipe : pipelined barrel shifter (SLL/SRL/SRA/ROR), one register    |
// |                per shift level, valid/ready on both sides. Rev 1.0         |
// +--------------------------------------------------------------------------+
module shifter_pipe #(
  parameter  int WIDTH = 32,
  parameter  int TAGW  = 4,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [1:0]       in_op,
  input  logic [TAGW-1:0]  in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAGW-1:0]  out_tag
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] data;
    logic [SHW-1:0]   amt;
    logic [1:0]       op;
    logic             rev;
    logic             sign;
    logic [TAGW-1:0]  tag;
  } stage_t;

  stage_t stage_q  [SHW];
  stage_t stage_d  [SHW];
  stage_t stage_in [SHW];
  stage_t entry;

  logic advance;
  logic accept;
  logic unused_last;

  function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = x[WIDTH-1-i];
    end
    return r;
  endfunction

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign accept   = in_valid && in_ready && !rst;

  always_comb begin
    entry = '0;
    if (accept) begin
      entry.valid = 1'b1;
      // Left shifts run through the right-shift core on reversed data.
      entry.data  = (in_op == OP_SLL) ? bit_rev(in_data) : in_data;
      entry.amt   = in_amt;
      entry.op    = in_op;
      entry.rev   = (in_op == OP_SLL);
      entry.sign  = in_data[WIDTH-1];
      entry.tag   = in_tag;
    end

    stage_in[0] = entry;
    for (int k = 1; k < SHW; k++) begin
      stage_in[k] = stage_q[k-1];
    end

    for (int k = 0; k < SHW; k++) begin
      stage_d[k] = stage_in[k];
      if (stage_in[k].amt[k]) begin
        case (stage_in[k].op)
          OP_ROR:  stage_d[k].data = (stage_in[k].data >> (1 << k))
                                   | (stage_in[k].data << (WIDTH - (1 << k)));
          OP_SRA:  stage_d[k].data = (stage_in[k].data >> (1 << k))
                                   | (stage_in[k].sign ? ~({WIDTH{1'b1}} >> (1 << k))
                                                       : {WIDTH{1'b0}});
          default: stage_d[k].data = stage_in[k].data >> (1 << k);
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SHW; k++) begin
        stage_q[k] <= '0;
      end
    end else if (advance) begin
      for (int k = 0; k < SHW; k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  assign out_valid = stage_q[SHW-1].valid;
  assign out_data  = stage_q[SHW-1].rev ? bit_rev(stage_q[SHW-1].data) : stage_q[SHW-1].data;
  assign out_tag   = stage_q[SHW-1].tag;

  // Control fields of the final stage have no further consumer.
  assign unused_last = ^{stage_q[SHW-1].amt, stage_q[SHW-1].op, stage_q[SHW-1].sign};

endmodule
`default_nettype wire

// File: tb/tb_shifter_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_shifter_pipe : scoreboard bench for shifter_pipe (32-bit and 8-bit).    |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
module tb_shifter_pipe;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  tag;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [4:0]  in_amt;
  logic [1:0]  in_op;
  logic [3:0]  in_tag, out_tag;

  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0]  in_data8, out_data8;
  logic [2:0]  in_amt8;
  logic [1:0]  in_op8;
  logic [3:0]  in_tag8, out_tag8;

  shifter_pipe #(.WIDTH(32), .TAGW(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_amt(in_amt),
    .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
  );

  shifter_pipe #(.WIDTH(8), .TAGW(4)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8), .in_amt(in_amt8),
    .in_op(in_op8), .in_tag(in_tag8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8), .out_tag(out_tag8)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   chk_lat, chk_lat8;
  exp_t q[$];
  exp_t q8[$];
  logic [3:0] tag_ctr, tag_ctr8;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: shift semantics straight from the mode definitions, w-bit wide.
  function automatic logic [63:0] ref_shift(input logic [63:0] d, input int a,
                                            input logic [1:0] op, input int w);
    logic [63:0] mask, r, dm;
    mask = (64'd1 << w) - 64'd1;
    dm   = d & mask;
    case (op)
      2'b00:   r = (dm << a) & mask;
      2'b01:   r = dm >> a;
      2'b10: begin
        r = dm >> a;
        if (dm[w-1]) r = r | (mask & ~(mask >> a));
      end
      default: r = ((dm >> a) | (dm << (w - a))) & mask;
    endcase
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  task automatic send(input logic [31:0] d, input logic [4:0] a, input logic [1:0] op);
    exp_t        e;
    logic [63:0] r;
    bit          done = 0;
    in_valid = 1'b1; in_data = d; in_amt = a; in_op = op; in_tag = tag_ctr;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clk);
      if (in_ready && !rst) begin
        r      = ref_shift({32'd0, d}, int'(a), op, 32);
        e.data = r[31:0];
        e.tag  = tag_ctr;
        e.cyc  = cyc;
        q.push_back(e);
        tag_ctr++;
        done = 1;
      end
      @(posedge clk); #1;
    end
    if (!done) timeout_fail("send32");
    in_valid = 1'b0;
  endtask

  task automatic send8(input logic [7:0] d, input logic [2:0] a, input logic [1:0] op);
    exp_t        e;
    logic [63:0] r;
    bit          done = 0;
    in_valid8 = 1'b1; in_data8 = d; in_amt8 = a; in_op8 = op; in_tag8 = tag_ctr8;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clk);
      if (in_ready8 && !rst) begin
        r      = ref_shift({56'd0, d}, int'(a), op, 8);
        e.data = r[31:0];
        e.tag  = tag_ctr8;
        e.cyc  = cyc;
        q8.push_back(e);
        tag_ctr8++;
        done = 1;
      end
      @(posedge clk); #1;
    end
    if (!done) timeout_fail("send8");
    in_valid8 = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (q.size() != 0 || q8.size() != 0); i++) @(posedge clk);
    if (q.size() != 0 || q8.size() != 0) timeout_fail("drain");
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_out32: got data %h tag %h, no result pending", out_data, out_tag);
      end else begin
        check("out_data32", {32'd0, out_data}, {32'd0, q[0].data});
        check("out_tag32", {60'd0, out_tag}, {60'd0, q[0].tag});
        if (out_ready) begin
          if (chk_lat) check("latency32", 64'(cyc - q[0].cyc), 64'd5);
          void'(q.pop_front());
        end else begin
          check("stall_in_ready", {63'd0, in_ready}, 64'd0);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid8) begin
      if (q8.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_out8: got data %h tag %h, no result pending", out_data8, out_tag8);
      end else begin
        check("out_data8", {56'd0, out_data8}, {32'd0, q8[0].data});
        check("out_tag8", {60'd0, out_tag8}, {60'd0, q8[0].tag});
        if (out_ready8) begin
          if (chk_lat8) check("latency8", 64'(cyc - q8[0].cyc), 64'd3);
          void'(q8.pop_front());
        end
      end
    end
  end

  initial begin
    bit rdone;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_amt = '0; in_op = '0; in_tag = '0;
    in_valid8 = 1'b0; in_data8 = '0; in_amt8 = '0; in_op8 = '0; in_tag8 = '0;
    out_ready = 1'b1; out_ready8 = 1'b1;
    tag_ctr = '0; tag_ctr8 = '0; chk_lat = 1; chk_lat8 = 1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data", {32'd0, out_data}, 64'd0);
    check("rst_out_tag", {60'd0, out_tag}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid8", {63'd0, out_valid8}, 64'd0);
    @(posedge clk); #1;

    // Back-to-back SRL sweep, exact latency on every result.
    for (int a = 0; a < 32; a++) send(32'hFFFF_FFFF, 5'(a), 2'b01);
    drain();

    // Directed mode and boundary cases.
    send(32'h0000_0001, 5'd31, 2'b00);
    send(32'h8000_0000, 5'd4,  2'b10);
    send(32'h7000_0000, 5'd4,  2'b10);
    send(32'h1234_5678, 5'd8,  2'b11);
    send(32'h1234_5678, 5'd0,  2'b11);
    send(32'h8000_0001, 5'd31, 2'b10);
    send(32'hA5C3_0F81, 5'd0,  2'b00);
    send(32'hA5C3_0F81, 5'd0,  2'b10);
    send(32'hA5C3_0F81, 5'd31, 2'b11);
    drain();

    // Backpressure: stall 10 cycles after the first result appears.
    chk_lat = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) send($urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
      end
      begin
        bit seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
          @(negedge clk);
          if (out_valid) seen = 1;
        end
        if (!seen) timeout_fail("first_out_valid");
        @(posedge clk); #1 out_ready = 1'b0;
        repeat (10) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three operations in flight; none may emerge.
    chk_lat = 1;
    send(32'h0F0F_0F0F, 5'd3, 2'b01);
    send(32'hF000_0000, 5'd7, 2'b10);
    send(32'h0000_00FF, 5'd9, 2'b00);
    rst = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD_BEEF; in_amt = 5'd1; in_op = 2'b01;
    q.delete();
    @(posedge clk); #1 rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_out_data", {32'd0, out_data}, 64'd0);
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    repeat (10) @(posedge clk);
    #1;
    send(32'h1234_5678, 5'd12, 2'b11);
    drain();

    // 8-bit instance: directed SRA plus random operations.
    send8(8'h90, 3'd3, 2'b10);
    send8(8'h90, 3'd7, 2'b10);
    for (int i = 0; i < 24; i++) send8(8'($urandom), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
    drain();

    // Random operations under random backpressure.
    chk_lat = 0;
    rdone   = 0;
    fork
      begin
        for (int i = 0; i < 150; i++) send($urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
        rdone = 1;
      end
      begin
        while (!rdone) begin
          @(posedge clk); #1 out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
